// File: rtl/load_store_initiator.sv
// Load/store initiator between the MEM stage and a word-organised data memory.
// Formats byte lanes, splits word-crossing accesses into two beats and extends load data.
module load_store_initiator #(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [2:0]            req_funct3,
   input  logic [DM_ADDRESS-1:0] req_addr,
   input  logic [DATA_W-1:0]     req_wdata,
   output logic                  resp_valid,
   output logic                  resp_err,
   output logic [DATA_W-1:0]     resp_rdata,
   output logic [DM_ADDRESS-1:0] mem_addr,
   output logic                  mem_re,
   output logic [3:0]            mem_wr,
   output logic [DATA_W-1:0]     mem_wdata,
   input  logic [DATA_W-1:0]     mem_rdata
);

   typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, CAP, RESP} state_t;

   state_t            state;
   logic              write_q;
   logic [2:0]        funct3_q;
   logic [1:0]        offset_q;
   logic              cross_q;
   logic [3:0]        be_hi_q;
   logic [DATA_W-1:0] wdata_hi_q;
   logic [DATA_W-1:0] word1;

   logic [3:0]        size_mask;
   logic [DATA_W-1:0] lane_mask;
   logic [7:0]        be_shift;
   logic [63:0]       data_shift;
   logic              legal;
   logic [55:0]       window;
   logic [DATA_W-1:0] load_word;
   logic [DATA_W-1:0] load_result;

   // Request-side lane formatting: enables and data are laid out over a two-word span,
   // the upper word being the second beat of a crossing access.
   always_comb begin
      size_mask = 4'b1111;
      case (req_funct3[1:0])
         2'b00:   size_mask = 4'b0001;
         2'b01:   size_mask = 4'b0011;
         default: size_mask = 4'b1111;
      endcase
      lane_mask  = {{8{size_mask[3]}}, {8{size_mask[2]}}, {8{size_mask[1]}}, {8{size_mask[0]}}};
      be_shift   = {4'b0000, size_mask} << req_addr[1:0];
      data_shift = {32'b0, req_wdata & lane_mask} << {req_addr[1:0], 3'b000};
      if (req_write)
         legal = !req_funct3[2] && (req_funct3[1:0] != 2'b11);
      else
         legal = (req_funct3[1:0] != 2'b11) && (req_funct3 != 3'b110);

      // Byte 7 of a two-word window can never be reached, so only seven bytes are kept.
      window = cross_q ? {mem_rdata[23:0], word1} : {24'b0, mem_rdata};
      case (offset_q)
         2'd0:    load_word = window[31:0];
         2'd1:    load_word = window[39:8];
         2'd2:    load_word = window[47:16];
         default: load_word = window[55:24];
      endcase
      case (funct3_q)
         3'b000:  load_result = {{24{load_word[7]}}, load_word[7:0]};
         3'b001:  load_result = {{16{load_word[15]}}, load_word[15:0]};
         3'b100:  load_result = {24'b0, load_word[7:0]};
         3'b101:  load_result = {16'b0, load_word[15:0]};
         default: load_result = load_word;
      endcase
   end

   // Transaction sequencer; every interface output is a register written here.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_addr   <= '0;
         mem_re     <= 1'b0;
         mem_wr     <= 4'b0000;
         mem_wdata  <= '0;
         write_q    <= 1'b0;
         funct3_q   <= 3'b000;
         offset_q   <= 2'b00;
         cross_q    <= 1'b0;
         be_hi_q    <= 4'b0000;
         wdata_hi_q <= '0;
         word1      <= '0;
      end else begin
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready  <= 1'b0;
                  write_q    <= req_write;
                  funct3_q   <= req_funct3;
                  offset_q   <= req_addr[1:0];
                  cross_q    <= |be_shift[7:4];
                  be_hi_q    <= be_shift[7:4];
                  wdata_hi_q <= data_shift[63:32];
                  if (!legal) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state     <= ISSUE1;
                     mem_addr  <= {req_addr[DM_ADDRESS-1:2], 2'b00};
                     mem_re    <= !req_write;
                     mem_wr    <= req_write ? be_shift[3:0] : 4'b0000;
                     mem_wdata <= req_write ? data_shift[31:0] : '0;
                  end
               end
            end
            ISSUE1: begin
               if (cross_q) begin
                  state     <= ISSUE2;
                  mem_addr  <= mem_addr + DM_ADDRESS'(4);
                  mem_re    <= !write_q;
                  mem_wr    <= write_q ? be_hi_q : 4'b0000;
                  mem_wdata <= write_q ? wdata_hi_q : '0;
               end else begin
                  mem_re    <= 1'b0;
                  mem_wr    <= 4'b0000;
                  mem_wdata <= '0;
                  if (write_q) begin
                     state      <= RESP;
                     resp_valid <= 1'b1;
                  end else begin
                     state <= CAP;
                  end
               end
            end
            ISSUE2: begin
               mem_re    <= 1'b0;
               mem_wr    <= 4'b0000;
               mem_wdata <= '0;
               word1     <= mem_rdata;
               if (write_q) begin
                  state      <= RESP;
                  resp_valid <= 1'b1;
               end else begin
                  state <= CAP;
               end
            end
            CAP: begin
               state      <= RESP;
               resp_valid <= 1'b1;
               resp_rdata <= load_result;
            end
            RESP: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
            default: begin
               state     <= IDLE;
               req_ready <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_initiator.sv
// Directed bench for load_store_initiator with a small byte-enabled word memory model.
module tb_load_store_initiator;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [8:0]  req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_err;
   logic [31:0] resp_rdata;
   logic [8:0]  mem_addr;
   logic        mem_re;
   logic [3:0]  mem_wr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic [31:0] mem [0:127];

   logic [8:0]  obsAddr  [1:8];
   logic [3:0]  obsWr    [1:8];
   logic [31:0] obsWdata [1:8];
   logic        obsRe    [1:8];
   int          lat;
   logic        errSeen;
   logic [31:0] rdataSeen;

   int total = 0;
   int bad   = 0;

   load_store_initiator #(.DM_ADDRESS(9), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
      .mem_addr(mem_addr), .mem_re(mem_re), .mem_wr(mem_wr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Word memory: read data appears the cycle after mem_re, writes honour byte enables.
   always @(posedge clk) begin
      if (mem_re)
         mem_rdata <= mem[mem_addr[8:2]];
      for (int i = 0; i < 4; i++)
         if (mem_wr[i])
            mem[mem_addr[8:2]][8*i +: 8] <= mem_wdata[8*i +: 8];
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one request for a single cycle; returns at the negedge of cycle T+1.
   task automatic applyStimulus(input logic w, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = d;
      @(negedge clk);
      req_valid  = 1'b0;
      req_wdata  = 32'h0;
   endtask

   task automatic runTxn(input logic w, input logic [2:0] f3, input logic [8:0] a, input logic [31:0] d);
      applyStimulus(w, f3, a, d);
      lat = 0;
      for (int c = 1; c <= 8 && lat == 0; c++) begin
         obsAddr[c]  = mem_addr;
         obsWr[c]    = mem_wr;
         obsWdata[c] = mem_wdata;
         obsRe[c]    = mem_re;
         if (resp_valid) begin
            lat       = c;
            errSeen   = resp_err;
            rdataSeen = resp_rdata;
         end
         @(negedge clk);
      end
      checkOutput("ready_after", req_ready, 1'b1);
      checkOutput("addr_align", obsAddr[1][1:0], 2'b00);
   endtask

   task automatic checkLoad(input string tag, input logic [2:0] f3, input logic [8:0] a,
                            input int expLat, input logic [31:0] expData);
      runTxn(1'b0, f3, a, 32'h0);
      checkOutput({tag, "_lat"}, lat, expLat);
      checkOutput({tag, "_err"}, errSeen, 1'b0);
      checkOutput({tag, "_data"}, rdataSeen, expData);
   endtask

   task automatic doStore(input string tag, input logic [2:0] f3, input logic [8:0] a,
                          input logic [31:0] d, input int expLat);
      runTxn(1'b1, f3, a, d);
      checkOutput({tag, "_lat"}, lat, expLat);
      checkOutput({tag, "_err"}, errSeen, 1'b0);
      checkOutput({tag, "_data"}, rdataSeen, 32'h0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
      req_funct3 = 3'b000; req_addr = 9'h0; req_wdata = 32'h0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rst_ready", req_ready, 1'b1);
      checkOutput("rst_resp_valid", resp_valid, 1'b0);
      checkOutput("rst_mem_re", mem_re, 1'b0);
      checkOutput("rst_mem_wr", mem_wr, 4'b0000);
      checkOutput("rst_mem_addr", mem_addr, 9'h000);
      checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
      checkOutput("rst_rdata", resp_rdata, 32'h0);

      doStore("sw8", 3'b010, 9'h008, 32'hDEADBEEF, 2);
      checkOutput("sw8_addr", obsAddr[1], 9'h008);
      checkOutput("sw8_wr", obsWr[1], 4'b1111);
      checkOutput("sw8_wdata", obsWdata[1], 32'hDEADBEEF);
      checkOutput("sw8_re", obsRe[1], 1'b0);
      checkLoad("lw8", 3'b010, 9'h008, 3, 32'hDEADBEEF);
      checkOutput("lw8_re", obsRe[1], 1'b1);

      doStore("sw8b", 3'b010, 9'h008, 32'h80FF1234, 2);
      checkLoad("lb_b", 3'b000, 9'h00B, 3, 32'hFFFFFF80);
      checkLoad("lbu_b", 3'b100, 9'h00B, 3, 32'h00000080);
      checkLoad("lh_8", 3'b001, 9'h008, 3, 32'h00001234);

      doStore("sw4", 3'b010, 9'h004, 32'h00000000, 2);
      doStore("sw6", 3'b010, 9'h006, 32'h11223344, 3);
      checkOutput("sw6_b1_addr", obsAddr[1], 9'h004);
      checkOutput("sw6_b1_wr", obsWr[1], 4'b1100);
      checkOutput("sw6_b1_wdata", obsWdata[1], 32'h33440000);
      checkOutput("sw6_b2_addr", obsAddr[2], 9'h008);
      checkOutput("sw6_b2_wr", obsWr[2], 4'b0011);
      checkOutput("sw6_b2_wdata", obsWdata[2], 32'h00001122);
      checkLoad("lw6", 3'b010, 9'h006, 4, 32'h11223344);
      checkLoad("lhu_a", 3'b101, 9'h00A, 3, 32'h000080FF);
      checkLoad("lh_a", 3'b001, 9'h00A, 3, 32'hFFFF80FF);

      doStore("sw1fc", 3'b010, 9'h1FC, 32'hAB000000, 2);
      doStore("sw0", 3'b010, 9'h000, 32'h000000CD, 2);
      checkLoad("lh_wrap", 3'b001, 9'h1FF, 4, 32'hFFFFCDAB);
      checkOutput("wrap_b1_addr", obsAddr[1], 9'h1FC);
      checkOutput("wrap_b2_addr", obsAddr[2], 9'h000);
      checkOutput("wrap_b2_re", obsRe[2], 1'b1);
      checkOutput("wrap_b2_wr", obsWr[2], 4'b0000);
      checkOutput("wrap_cap_re", obsRe[3], 1'b0);

      doStore("sb3", 3'b000, 9'h003, 32'h123456A5, 2);
      checkOutput("sb3_wr", obsWr[1], 4'b1000);
      checkOutput("sb3_wdata", obsWdata[1], 32'hA5000000);
      checkLoad("lw0", 3'b010, 9'h000, 3, 32'hA50000CD);

      runTxn(1'b0, 3'b011, 9'h008, 32'h0);
      checkOutput("ill_ld_lat", lat, 1);
      checkOutput("ill_ld_err", errSeen, 1'b1);
      checkOutput("ill_ld_data", rdataSeen, 32'h0);
      checkOutput("ill_ld_re", obsRe[1], 1'b0);
      checkOutput("ill_ld_wr", obsWr[1], 4'b0000);
      runTxn(1'b1, 3'b100, 9'h008, 32'hFFFFFFFF);
      checkOutput("ill_st_lat", lat, 1);
      checkOutput("ill_st_err", errSeen, 1'b1);
      checkOutput("ill_st_wr", obsWr[1], 4'b0000);
      checkLoad("ill_st_keep", 3'b010, 9'h008, 3, 32'h80FF1122);

      applyStimulus(1'b1, 3'b010, 9'h006, 32'h55667788);
      @(negedge clk);
      checkOutput("rstmid_b2_wr", mem_wr, 4'b0011);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rstmid_wr", mem_wr, 4'b0000);
      checkOutput("rstmid_resp", resp_valid, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("rstmid_ready", req_ready, 1'b1);
      checkOutput("rstmid_resp2", resp_valid, 1'b0);
      checkOutput("rstmid_re", mem_re, 1'b0);
      checkLoad("post_rst", 3'b010, 9'h000, 3, 32'hA50000CD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
